// File: rtl/reg_sequencer.sv
// Instruction sequencer for the 8-entry register file: decodes MOV/ALU/LDI/NOP/HALT
// bytes into registered one-hot strobes. Optional turnaround slot: REG_SEQ_BUS_GUARD_EN.
module reg_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] instr,
    input  logic       instr_valid,
    output logic       instr_ready,
    output logic [7:0] write_en,
    output logic [7:0] read_en,
    output logic [2:0] alu_op,
    output logic       alu_latch,
    output logic       imm_oe,
    output logic [7:0] imm_out,
    output logic       done,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_XFER,
        S_OPND,
        S_WB,
        S_LDI_WAIT,
        S_HALT
`ifdef REG_SEQ_BUS_GUARD_EN
        , S_GUARD
`endif
    } state_t;

    // K_ACC covers both ALU ops and MOV-to-accumulator (op forced to PASS)
    typedef enum logic [1:0] {
        K_NOP,
        K_MOV,
        K_ACC,
        K_LDI
    } kind_t;

    state_t     state_q, state_d;
    kind_t      kind_q, kind_d;
    logic [2:0] dst_q, dst_d;
    logic [2:0] src_q, src_d;
    logic [2:0] op_q, op_d;
    logic [7:0] imm_d;
    logic       accept;

    logic       ready_d;
    logic [7:0] write_en_d;
    logic [7:0] read_en_d;
    logic [2:0] alu_op_d;
    logic       alu_latch_d;
    logic       imm_oe_d;
    logic       done_d;
    logic       halted_d;

    function automatic logic [7:0] onehot(input logic [2:0] idx);
        logic [7:0] v;
        v = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (idx == i[2:0]) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic state_t retire_state();
`ifdef REG_SEQ_BUS_GUARD_EN
        return S_GUARD;
`else
        return S_IDLE;
`endif
    endfunction

    assign accept = instr_valid && instr_ready;

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        dst_d   = dst_q;
        src_d   = src_q;
        op_d    = op_q;
        imm_d   = imm_out;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (instr[7:6])
                        2'b00: begin
                            dst_d = instr[5:3];
                            src_d = instr[2:0];
                            op_d  = '0;
                            if (instr[5:3] == 3'd7) begin
                                kind_d  = K_ACC;
                                state_d = S_OPND;
                            end else if (instr[5:3] == instr[2:0]) begin
                                kind_d  = K_NOP;
                                state_d = S_XFER;
                            end else begin
                                kind_d  = K_MOV;
                                state_d = S_XFER;
                            end
                        end
                        2'b01: begin
                            kind_d  = K_ACC;
                            op_d    = instr[5:3];
                            src_d   = instr[2:0];
                            state_d = S_OPND;
                        end
                        2'b10: begin
                            kind_d  = K_LDI;
                            dst_d   = instr[2:0];
                            op_d    = '0;
                            state_d = S_LDI_WAIT;
                        end
                        default: begin
                            if (instr[5:0] == 6'h3F) begin
                                state_d = S_HALT;
                            end else begin
                                kind_d  = K_NOP;
                                state_d = S_XFER;
                            end
                        end
                    endcase
                end
            end
            S_LDI_WAIT: begin
                if (accept) begin
                    imm_d   = instr;
                    state_d = S_XFER;
                end
            end
            // LDI into the accumulator must pass through the ALU, so it takes a WB cycle
            S_XFER: begin
                if (kind_q == K_LDI && dst_q == 3'd7) state_d = S_WB;
                else                                   state_d = retire_state();
            end
            S_OPND:  state_d = S_WB;
            S_WB:    state_d = retire_state();
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered in that state
    always_comb begin
        ready_d     = 1'b0;
        write_en_d  = '0;
        read_en_d   = '0;
        alu_op_d    = '0;
        alu_latch_d = 1'b0;
        imm_oe_d    = 1'b0;
        done_d      = 1'b0;
        halted_d    = 1'b0;

        case (state_d)
            S_IDLE, S_LDI_WAIT: ready_d = 1'b1;
            S_XFER: begin
                case (kind_d)
                    K_MOV: begin
                        read_en_d  = onehot(src_d);
                        write_en_d = onehot(dst_d);
                        done_d     = 1'b1;
                    end
                    K_LDI: begin
                        imm_oe_d = 1'b1;
                        if (dst_d == 3'd7) begin
                            alu_latch_d = 1'b1;
                        end else begin
                            write_en_d = onehot(dst_d);
                            done_d     = 1'b1;
                        end
                    end
                    default: done_d = 1'b1;
                endcase
            end
            S_OPND: begin
                read_en_d   = onehot(src_d);
                alu_latch_d = 1'b1;
                alu_op_d    = op_d;
            end
            S_WB: begin
                write_en_d = 8'h80;
                alu_op_d   = op_d;
                done_d     = 1'b1;
            end
            S_HALT:  halted_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            kind_q      <= K_NOP;
            dst_q       <= '0;
            src_q       <= '0;
            op_q        <= '0;
            imm_out     <= '0;
            instr_ready <= 1'b0;
            write_en    <= '0;
            read_en     <= '0;
            alu_op      <= '0;
            alu_latch   <= 1'b0;
            imm_oe      <= 1'b0;
            done        <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            dst_q       <= dst_d;
            src_q       <= src_d;
            op_q        <= op_d;
            imm_out     <= imm_d;
            instr_ready <= ready_d;
            write_en    <= write_en_d;
            read_en     <= read_en_d;
            alu_op      <= alu_op_d;
            alu_latch   <= alu_latch_d;
            imm_oe      <= imm_oe_d;
            done        <= done_d;
            halted      <= halted_d;
        end
    end

endmodule
